// File: rtl/led_pkg.sv
// Shared types and constants for the LED chain node.
//   state_e      : frame FSM states
//   *_DEF        : default pulse timings in clocks at 100 MHz
//   pix_slice()  : LSB position of pixel p in a packed frame
package led_pkg;

    typedef enum logic [1:0] {
        WAIT_GAP = 2'd0,
        CAPTURE  = 2'd1,
        FORWARD  = 2'd2
    } state_e;

    localparam int unsigned T_ONE_DEF      = 60;
    localparam int unsigned T_HIGH_MAX_DEF = 120;
    localparam int unsigned T_RESET_DEF    = 5000;

    function automatic int unsigned pix_slice(input int unsigned p, input int unsigned bpp);
        return p * bpp;
    endfunction

endpackage

// File: rtl/led_bit_decoder.sv
// Pulse-width decoder for the single-wire LED stream.
//   clk_i, rst_ni : clock, async active-low reset
//   serial_i      : raw asynchronous line
//   s_in_o        : synchronised line level
//   bit_valid_o   : one-cycle strobe, a well-formed pulse ended
//   bit_val_o     : decoded value, qualified by bit_valid_o
//   gap_valid_o   : one-cycle strobe, low time reached T_RESET
//   pulse_err_o   : one-cycle strobe, a pulse exceeded T_HIGH_MAX
module led_bit_decoder
    import led_pkg::*;
#(
    parameter int unsigned CWIDTH        = 13,
    parameter int unsigned DEBOUNCEWIDTH = 2,
    parameter int unsigned T_ONE         = T_ONE_DEF,
    parameter int unsigned T_HIGH_MAX    = T_HIGH_MAX_DEF,
    parameter int unsigned T_RESET       = T_RESET_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic serial_i,
    output logic s_in_o,
    output logic bit_valid_o,
    output logic bit_val_o,
    output logic gap_valid_o,
    output logic pulse_err_o
);

    localparam logic [CWIDTH-1:0] CNT_MAX = '1;

    logic [DEBOUNCEWIDTH-1:0] sync_q, sync_d;
    logic                     s_prev_q;
    logic [CWIDTH-1:0]        hi_cnt_q, hi_cnt_d;
    logic [CWIDTH-1:0]        lo_cnt_q, lo_cnt_d;
    logic                     armed_q, armed_d;
    logic                     bit_valid_q, bit_valid_d;
    logic                     bit_val_q, bit_val_d;
    logic                     gap_valid_q, gap_valid_d;
    logic                     pulse_err_q, pulse_err_d;
    logic                     s_in, rise, fall, gap_hit;

    assign s_in = sync_q[DEBOUNCEWIDTH-1];

    // Counters, edge detect and event generation
    always_comb begin
        sync_d   = {sync_q[DEBOUNCEWIDTH-2:0], serial_i};
        rise     = s_in & ~s_prev_q;
        fall     = ~s_in & s_prev_q;
        hi_cnt_d = hi_cnt_q;
        lo_cnt_d = lo_cnt_q;
        armed_d  = armed_q;

        if (rise) begin
            hi_cnt_d = CWIDTH'(1);
        end else if (s_in && hi_cnt_q != CNT_MAX) begin
            hi_cnt_d = hi_cnt_q + CWIDTH'(1);
        end

        if (fall) begin
            lo_cnt_d = CWIDTH'(1);
        end else if (!s_in && lo_cnt_q != CNT_MAX) begin
            lo_cnt_d = lo_cnt_q + CWIDTH'(1);
        end

        // Armed flag keeps a saturated low counter from re-firing the gap
        gap_hit = armed_q & ~s_in & (lo_cnt_d == CWIDTH'(T_RESET));
        if (rise) begin
            armed_d = 1'b1;
        end else if (gap_hit) begin
            armed_d = 1'b0;
        end

        // hi_cnt_q still holds the finished pulse width on the falling-edge cycle
        bit_valid_d = fall & (hi_cnt_q <= CWIDTH'(T_HIGH_MAX));
        bit_val_d   = (hi_cnt_q >= CWIDTH'(T_ONE));
        pulse_err_d = fall & (hi_cnt_q > CWIDTH'(T_HIGH_MAX));
        gap_valid_d = gap_hit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= '0;
            s_prev_q    <= 1'b0;
            hi_cnt_q    <= '0;
            lo_cnt_q    <= '0;
            armed_q     <= 1'b1;
            bit_valid_q <= 1'b0;
            bit_val_q   <= 1'b0;
            gap_valid_q <= 1'b0;
            pulse_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            s_prev_q    <= s_in;
            hi_cnt_q    <= hi_cnt_d;
            lo_cnt_q    <= lo_cnt_d;
            armed_q     <= armed_d;
            bit_valid_q <= bit_valid_d;
            bit_val_q   <= bit_val_d;
            gap_valid_q <= gap_valid_d;
            pulse_err_q <= pulse_err_d;
        end
    end

    assign s_in_o      = s_in;
    assign bit_valid_o = bit_valid_q;
    assign bit_val_o   = bit_val_q;
    assign gap_valid_o = gap_valid_q;
    assign pulse_err_o = pulse_err_q;

endmodule

// File: rtl/led_chain_node.sv
// Daisy-chainable LED node: captures NUM_PIX pixels of BPP bits from the
// pulse-width stream, forwards the rest, and latches the frame on a gap.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_serial       : stream in from the previous node or board pin
//   o_serial       : forwarded stream to the next node
//   o_led_data     : latched frame, pixel p at [p*BPP +: BPP]
//   o_latch        : one-cycle strobe on o_led_data update
//   o_err          : sticky error, cleared by the next good latch
module led_chain_node
    import led_pkg::*;
#(
    parameter int unsigned NUM_PIX       = 1,
    parameter int unsigned BPP           = 24,
    parameter int unsigned CWIDTH        = 13,
    parameter int unsigned DEBOUNCEWIDTH = 2,
    parameter int unsigned T_ONE         = T_ONE_DEF,
    parameter int unsigned T_HIGH_MAX    = T_HIGH_MAX_DEF,
    parameter int unsigned T_RESET       = T_RESET_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_serial,
    output logic                     o_serial,
    output logic [NUM_PIX*BPP-1:0]   o_led_data,
    output logic                     o_latch,
    output logic                     o_err
);

    localparam int unsigned NBITS = NUM_PIX * BPP;
    localparam int unsigned IDXW  = $clog2(NBITS + 1);

    logic s_in, bit_valid, bit_val, gap_valid, pulse_err;

    state_e             state_q, state_d;
    logic [IDXW-1:0]    bit_idx_q, bit_idx_d;
    logic [NBITS-1:0]   cap_q, cap_d;
    logic [NBITS-1:0]   led_q, led_d;
    logic [NBITS-1:0]   frame_ordered;
    logic               serial_q, serial_d;
    logic               latch_q, latch_d;
    logic               err_q, err_d;
    logic               bad_q, bad_d;

    led_bit_decoder #(
        .CWIDTH        (CWIDTH),
        .DEBOUNCEWIDTH (DEBOUNCEWIDTH),
        .T_ONE         (T_ONE),
        .T_HIGH_MAX    (T_HIGH_MAX),
        .T_RESET       (T_RESET)
    ) u_dec (
        .clk_i       (i_clk),
        .rst_ni      (i_rst_n),
        .serial_i    (i_serial),
        .s_in_o      (s_in),
        .bit_valid_o (bit_valid),
        .bit_val_o   (bit_val),
        .gap_valid_o (gap_valid),
        .pulse_err_o (pulse_err)
    );

    // Capture shifts in at the LSB, so the first pixel ends up in the top
    // slice; reverse pixel order so pixel 0 lands at the bottom of the frame.
    always_comb begin
        frame_ordered = '0;
        for (int unsigned p = 0; p < NUM_PIX; p++) begin
            frame_ordered[pix_slice(p, BPP) +: BPP] = cap_q[pix_slice(NUM_PIX - 1 - p, BPP) +: BPP];
        end
    end

    // Frame FSM
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        cap_d     = cap_q;
        led_d     = led_q;
        latch_d   = 1'b0;
        err_d     = err_q;
        bad_d     = bad_q;
        serial_d  = (state_q == FORWARD) ? s_in : 1'b0;

        if (pulse_err) begin
            err_d = 1'b1;
            bad_d = 1'b1;
        end

        case (state_q)
            WAIT_GAP: begin
                if (gap_valid) begin
                    state_d   = CAPTURE;
                    bit_idx_d = '0;
                    bad_d     = 1'b0;
                end
            end
            CAPTURE: begin
                if (bit_valid) begin
                    cap_d     = {cap_q[NBITS-2:0], bit_val};
                    bit_idx_d = bit_idx_q + IDXW'(1);
                    if (bit_idx_q == IDXW'(NBITS - 1)) begin
                        state_d = FORWARD;
                    end
                end else if (gap_valid) begin
                    // A gap mid-frame means the frame was short
                    if (bit_idx_q != '0) begin
                        err_d = 1'b1;
                    end
                    bit_idx_d = '0;
                    bad_d     = 1'b0;
                end
            end
            FORWARD: begin
                if (gap_valid) begin
                    if (!bad_q) begin
                        led_d   = frame_ordered;
                        latch_d = 1'b1;
                        err_d   = 1'b0;
                    end
                    bit_idx_d = '0;
                    bad_d     = 1'b0;
                    state_d   = CAPTURE;
                end
            end
            default: state_d = WAIT_GAP;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= WAIT_GAP;
            bit_idx_q <= '0;
            cap_q     <= '0;
            led_q     <= '0;
            serial_q  <= 1'b0;
            latch_q   <= 1'b0;
            err_q     <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            cap_q     <= cap_d;
            led_q     <= led_d;
            serial_q  <= serial_d;
            latch_q   <= latch_d;
            err_q     <= err_d;
            bad_q     <= bad_d;
        end
    end

    assign o_serial   = serial_q;
    assign o_led_data = led_q;
    assign o_latch    = latch_q;
    assign o_err      = err_q;

endmodule
